// File: rtl/sample_capture_pkg.sv
// Shared types and constants for the sample_capture block: FSM states,
// decimation mode encodings and mode normalisation.
package sample_capture_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH
    } state_t;

    typedef enum logic [MODE_W-1:0] {
        MODE_DIV1     = 3'd0,
        MODE_DIV10    = 3'd1,
        MODE_DIV100   = 3'd2,
        MODE_DIV1000  = 3'd3,
        MODE_DIV10000 = 3'd4
    } mode_t;

    // Codes above the last defined mode behave as full rate.
    function automatic logic [MODE_W-1:0] norm_mode(input logic [MODE_W-1:0] m);
        return (m > MODE_DIV10000) ? MODE_DIV1 : m;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through FIFO with synchronous clear and an
// explicit occupancy counter; a push on a full FIFO is accepted only with a pop.
module sample_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_clr,
    input  logic [WIDTH-1:0]       i_data,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_level == LVL_FULL);
    assign o_empty   = (r_level == '0);
    assign w_push_ok = i_push & (~o_full | i_pop);
    assign w_pop_ok  = i_pop & ~o_empty;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push_ok & ~w_pop_ok)
                r_level <= r_level + 1'b1;
            else if (w_pop_ok & ~w_push_ok)
                r_level <= r_level - 1'b1;
        end
    end

    // NOTE: storage has no reset; entries are only observable once written.
    always_ff @(posedge i_clk) begin
        if (w_push_ok & ~i_clr)
            r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_level = r_level;

endmodule

// File: rtl/sample_capture.sv
// Sample capture front end: arms on Ready, buffers Enable-strobed samples and
// flushes on a mode change. Define SAMPLE_MODE_TAG_EN to store and expose Out_mode.
module sample_capture
    import sample_capture_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 16
) (
    input  logic                   Fg_clk,
    input  logic                   Reset,
    input  logic                   Ready,
    input  logic                   Enable,
    input  logic [MODE_W-1:0]      Mode,
    input  logic [DATA_W-1:0]      Din,
    output logic                   Out_valid,
    input  logic                   Out_ready,
    output logic [DATA_W-1:0]      Out_data,
`ifdef SAMPLE_MODE_TAG_EN
    output logic [MODE_W-1:0]      Out_mode,
`endif
    output logic [$clog2(DEPTH):0] Level,
    output logic                   Armed,
    output logic                   Overflow
);
`ifdef SAMPLE_MODE_TAG_EN
    localparam int WORD_W = MODE_W + DATA_W;
`else
    localparam int WORD_W = DATA_W;
`endif

    state_t             r_state;
    state_t             w_state_nxt;
    logic [MODE_W-1:0]  r_mode_q;
    logic [MODE_W-1:0]  w_mode_in;
    logic               w_mode_chg;
    logic               w_load_mode;
    logic               w_push;
    logic               w_pop;
    logic               w_clr;
    logic               w_full;
    logic               w_empty;
    logic               r_overflow;
    logic [WORD_W-1:0]  w_wr_word;
    logic [WORD_W-1:0]  w_rd_word;

    assign w_mode_in  = norm_mode(Mode);
    assign w_mode_chg = (w_mode_in != r_mode_q);
    assign Out_valid  = (r_state == ST_RUN) & ~w_empty;
    assign Armed      = (r_state != ST_IDLE);
    assign Overflow   = r_overflow;

    always_ff @(posedge Fg_clk or posedge Reset) begin
        if (Reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_clr       = 1'b0;
        w_load_mode = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (Ready) begin
                    w_state_nxt = ST_RUN;
                    w_load_mode = 1'b1;
                end
            end
            ST_RUN: begin
                w_pop = Out_valid & Out_ready;
                if (w_mode_chg) w_state_nxt = ST_FLUSH;
                else            w_push      = Enable;
            end
            ST_FLUSH: begin
                w_clr       = 1'b1;
                w_load_mode = 1'b1;
                w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Fg_clk or posedge Reset) begin
        if (Reset)            r_mode_q <= '0;
        else if (w_load_mode) r_mode_q <= w_mode_in;
    end

    // Sticky until the next flush; a push that coincides with a pop is never a drop.
    always_ff @(posedge Fg_clk or posedge Reset) begin
        if (Reset)                          r_overflow <= 1'b0;
        else if (w_clr)                     r_overflow <= 1'b0;
        else if (w_push & w_full & ~w_pop)  r_overflow <= 1'b1;
    end

`ifdef SAMPLE_MODE_TAG_EN
    assign w_wr_word = {r_mode_q, Din};
    assign Out_mode  = Out_valid ? w_rd_word[WORD_W-1 -: MODE_W] : '0;
`else
    assign w_wr_word = Din;
`endif
    assign Out_data  = Out_valid ? w_rd_word[DATA_W-1:0] : '0;

    sample_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (Fg_clk),
        .i_rst   (Reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clr   (w_clr),
        .i_data  (w_wr_word),
        .o_data  (w_rd_word),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (Level)
    );

endmodule

// File: tb/tb_sample_capture.sv
// Bench for sample_capture: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_sample_capture;

    localparam int DATA_W = 12;
    localparam int DEPTH  = 16;
    localparam int MODE_W = 3;

    logic              Fg_clk    = 1'b0;
    logic              Reset     = 1'b1;
    logic              Ready     = 1'b0;
    logic              Enable    = 1'b0;
    logic [MODE_W-1:0] Mode      = '0;
    logic [DATA_W-1:0] Din       = '0;
    logic              Out_ready = 1'b0;
    logic              Out_valid;
    logic [DATA_W-1:0] Out_data;
`ifdef SAMPLE_MODE_TAG_EN
    logic [MODE_W-1:0] Out_mode;
`endif
    logic [4:0]        Level;
    logic              Armed;
    logic              Overflow;

    int total = 0;
    int bad   = 0;

    always #5 Fg_clk = ~Fg_clk;

    sample_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .Fg_clk    (Fg_clk),
        .Reset     (Reset),
        .Ready     (Ready),
        .Enable    (Enable),
        .Mode      (Mode),
        .Din       (Din),
        .Out_valid (Out_valid),
        .Out_ready (Out_ready),
        .Out_data  (Out_data),
`ifdef SAMPLE_MODE_TAG_EN
        .Out_mode  (Out_mode),
`endif
        .Level     (Level),
        .Armed     (Armed),
        .Overflow  (Overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {mode, data} words plus a few flags.
    typedef logic [MODE_W+DATA_W-1:0] word_t;
    word_t             mq[$];
    bit                m_armed = 1'b0;
    bit                m_flush = 1'b0;
    bit                m_ovf   = 1'b0;
    logic [MODE_W-1:0] m_mode  = '0;

    function automatic logic [MODE_W-1:0] nm(input logic [MODE_W-1:0] m);
        return (m > 3'd4) ? 3'd0 : m;
    endfunction

    always @(posedge Fg_clk or posedge Reset) begin
        if (Reset) begin
            mq.delete();
            m_armed = 1'b0;
            m_flush = 1'b0;
            m_ovf   = 1'b0;
            m_mode  = '0;
        end else if (!m_armed) begin
            if (Ready) begin
                m_armed = 1'b1;
                m_mode  = nm(Mode);
            end
        end else if (m_flush) begin
            mq.delete();
            m_ovf   = 1'b0;
            m_mode  = nm(Mode);
            m_flush = 1'b0;
        end else begin
            if (mq.size() > 0 && Out_ready) void'(mq.pop_front());
            if (nm(Mode) != m_mode) m_flush = 1'b1;
            else if (Enable) begin
                if (mq.size() < DEPTH) mq.push_back({m_mode, Din});
                else                   m_ovf = 1'b1;
            end
        end
    end

    bit                cmp_on = 1'b0;
    bit                e_valid;
    logic [DATA_W-1:0] e_data;
    logic [MODE_W-1:0] e_mode;

    always @(negedge Fg_clk) begin
        if (cmp_on) begin
            e_valid = m_armed && !m_flush && (mq.size() > 0);
            e_data  = e_valid ? mq[0][DATA_W-1:0] : '0;
            e_mode  = e_valid ? mq[0][MODE_W+DATA_W-1:DATA_W] : '0;
            check("m_valid", 32'(Out_valid), 32'(e_valid));
            check("m_data", 32'(Out_data), 32'(e_data));
            check("m_level", 32'(Level), 32'(mq.size()));
            check("m_armed", 32'(Armed), 32'(m_armed));
            check("m_ovf", 32'(Overflow), 32'(m_ovf));
`ifdef SAMPLE_MODE_TAG_EN
            check("m_mode", 32'(Out_mode), 32'(e_mode));
`endif
        end
    end

    // Inputs are applied just after an edge and consumed by the next one.
    task automatic step(input logic rdy, input logic en, input logic [MODE_W-1:0] md,
                        input logic [DATA_W-1:0] d, input logic ordy);
        Ready     = rdy;
        Enable    = en;
        Mode      = md;
        Din       = d;
        Out_ready = ordy;
        @(posedge Fg_clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge Fg_clk);
        #1;
        cmp_on = 1'b1;
        check("rst_level", 32'(Level), 32'd0);
        check("rst_valid", 32'(Out_valid), 32'd0);
        check("rst_armed", 32'(Armed), 32'd0);
        check("rst_ovf", 32'(Overflow), 32'd0);
        check("rst_data", 32'(Out_data), 32'd0);
        Reset = 1'b0;

        // Enable before arming is ignored.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 3'd0, 12'(i + 7), 1'b0);
        check("idle_level", 32'(Level), 32'd0);
        check("idle_valid", 32'(Out_valid), 32'd0);
        check("idle_armed", 32'(Armed), 32'd0);

        // Arm, capture 1..4, then drain in order.
        step(1'b1, 1'b0, 3'd0, 12'd0, 1'b0);
        check("arm_armed", 32'(Armed), 32'd1);
        for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 3'd0, 12'(i), 1'b0);
        check("cap4_level", 32'(Level), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            check("drain4_valid", 32'(Out_valid), 32'd1);
            check("drain4_data", 32'(Out_data), 32'(i));
            step(1'b0, 1'b0, 3'd0, 12'd0, 1'b1);
        end
        check("drain4_empty", 32'(Out_valid), 32'd0);

        // Overflow: 17 pushes into a 16-deep FIFO, no pops.
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 3'd0, 12'(100 + i), 1'b0);
        step(1'b0, 1'b1, 3'd0, 12'd999, 1'b0);
        check("ovf_flag", 32'(Overflow), 32'd1);
        check("ovf_level", 32'(Level), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check("ovf_drain", 32'(Out_data), 32'(100 + i));
            step(1'b0, 1'b0, 3'd0, 12'd0, 1'b1);
        end
        check("ovf_drained", 32'(Out_valid), 32'd0);
        check("ovf_sticky", 32'(Overflow), 32'd1);

        // Mode change flushes and clears the sticky flag.
        step(1'b0, 1'b0, 3'd1, 12'd0, 1'b0);
        step(1'b0, 1'b0, 3'd1, 12'd0, 1'b0);
        check("flush_ovf", 32'(Overflow), 32'd0);

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 3'd1, 12'(200 + i), 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("fullpp_head", 32'(Out_data), 32'(200 + i));
            step(1'b0, 1'b1, 3'd1, 12'(300 + i), 1'b1);
            check("fullpp_level", 32'(Level), 32'd16);
            check("fullpp_ovf", 32'(Overflow), 32'd0);
        end
        for (int i = 3; i < 19; i++) begin
            check("fullpp_drain", 32'(Out_data), (i < 16) ? 32'(200 + i) : 32'(300 + i - 16));
            step(1'b0, 1'b0, 3'd1, 12'd0, 1'b1);
        end
        check("fullpp_empty", 32'(Level), 32'd0);

        // Level 5 with Overflow set, then switch mode 1 -> 3.
        for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 3'd1, 12'(400 + i), 1'b0);
        for (int i = 0; i < 11; i++) step(1'b0, 1'b0, 3'd1, 12'd0, 1'b1);
        check("pre_flush_level", 32'(Level), 32'd5);
        check("pre_flush_ovf", 32'(Overflow), 32'd1);
        step(1'b0, 1'b1, 3'd3, 12'hABC, 1'b0);
        check("chg_valid", 32'(Out_valid), 32'd0);
        step(1'b0, 1'b1, 3'd3, 12'hABD, 1'b0);
        check("post_flush_level", 32'(Level), 32'd0);
        check("post_flush_ovf", 32'(Overflow), 32'd0);
        check("post_flush_valid", 32'(Out_valid), 32'd0);
        step(1'b0, 1'b0, 3'd3, 12'd0, 1'b1);
        check("no_chg_sample", 32'(Out_valid), 32'd0);

        // Asynchronous reset mid-burst.
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 3'd3, 12'(500 + i), 1'b0);
        check("burst_level", 32'(Level), 32'd7);
        #2 Reset = 1'b1;
        #1;
        check("async_level", 32'(Level), 32'd0);
        check("async_armed", 32'(Armed), 32'd0);
        check("async_valid", 32'(Out_valid), 32'd0);
        @(negedge Fg_clk);
        Reset = 1'b0;
        @(posedge Fg_clk);
        #1;
        step(1'b1, 1'b0, 3'd2, 12'd0, 1'b0);
        step(1'b0, 1'b1, 3'd2, 12'h055, 1'b0);
        check("rearm_data", 32'(Out_data), 32'h055);
        check("rearm_level", 32'(Level), 32'd1);
`ifdef SAMPLE_MODE_TAG_EN
        check("rearm_mode", 32'(Out_mode), 32'd2);
`endif

        // Randomized traffic, with one reset pulse in the middle.
        begin
            logic [MODE_W-1:0] cur_mode = 3'd2;
            for (int i = 0; i < 800; i++) begin
                logic              r_rdy;
                logic              r_en;
                logic              r_ordy;
                logic [DATA_W-1:0] r_din;
                if ($urandom_range(0, 29) == 0) cur_mode = 3'($urandom_range(0, 4));
                r_rdy  = ($urandom_range(0, 19) == 0);
                r_en   = ($urandom_range(0, 9) < 6);
                r_ordy = ((i / 100) % 2 == 1) ? ($urandom_range(0, 9) < 8)
                                              : ($urandom_range(0, 9) < 3);
                r_din  = 12'($urandom());
                if (i == 400) Reset = 1'b1;
                if (i == 401) Reset = 1'b0;
                step(r_rdy, r_en, cur_mode, r_din, r_ordy);
            end
        end

        @(posedge Fg_clk);
        cmp_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
